elevator_scan_ctrl: RTL and testbench

ELEVATOR_SCAN_CTRL -- requirements
Module: elevator_scan_ctrl

---
 rtl/elevator_pkg.sv | 29 ++
 rtl/elevator_req_scan.sv | 28 ++
 rtl/elevator_scan_ctrl.sv | 171 +++++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types, direction encoding and default parameters for the elevator controller.
// Idle homing is built only when ELEVATOR_IDLE_HOME_EN is defined.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE      = 2'd1,
    DOOR_OPEN = 2'd2,
    EMERG     = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEF_NUM_FLOORS    = 4;
  localparam int DEF_DOOR_CYCLES   = 3;
  localparam int DEF_TRAVEL_CYCLES = 2;
  localparam int DEF_IDLE_CYCLES   = 8;

  // Counters hold at most (cycles - 1), so one shared width covers all timers.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/elevator_req_scan.sv
// Pending-call search relative to a floor: anything strictly above, below,
// or ahead in the given travel direction.
module elevator_req_scan
  import elevator_pkg::*;
#(
  parameter int  NUM_FLOORS = DEF_NUM_FLOORS,
  localparam int FLOOR_W    = ($clog2(NUM_FLOORS) < 1) ? 1 : $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    floor,
  input  logic                  direction,
  output logic                  any_above,
  output logic                  any_below,
  output logic                  any_ahead
);

  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (i > int'(floor))) any_above = 1'b1;
      if (pending[i] && (i < int'(floor))) any_below = 1'b1;
    end
  end

  assign any_ahead = (direction == DIR_UP) ? any_above : any_below;

endmodule

// File: rtl/elevator_scan_ctrl.sv
// Elevator car controller serving latched floor calls in SCAN order.
// Define ELEVATOR_IDLE_HOME_EN to send a car left idle away from floor 0 back home.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int  NUM_FLOORS    = DEF_NUM_FLOORS,
  parameter int  DOOR_CYCLES   = DEF_DOOR_CYCLES,
  parameter int  TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
  parameter int  IDLE_CYCLES   = DEF_IDLE_CYCLES,
  localparam int FLOOR_W       = ($clog2(NUM_FLOORS) < 1) ? 1 : $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  emergency,
  input  logic                  call_valid,
  input  logic [FLOOR_W-1:0]    call_floor,
  output logic                  call_ready,
  output logic [FLOOR_W-1:0]    floor,
  output logic                  door,
  output logic                  direction,
  output logic                  moving,
  output logic [NUM_FLOORS-1:0] pending
);

  // state     | meaning
  // IDLE      | parked, door closed, waiting for a pending call
  // MOVE      | travelling, one floor per TRAVEL_CYCLES
  // DOOR_OPEN | stopped at a served floor, door open for DOOR_CYCLES
  // EMERG     | emergency stop, door open, calls refused

  localparam int                 CNT_W       = cnt_width(DOOR_CYCLES, TRAVEL_CYCLES, IDLE_CYCLES);
  localparam logic [CNT_W-1:0]   DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

  state_t                  state, state_n;
  logic [FLOOR_W-1:0]      floor_n, floor_step, scan_floor;
  logic                    dir_n;
  logic [NUM_FLOORS-1:0]   pending_n, set_mask, clear_mask;
  logic [CNT_W-1:0]        travel_cnt, travel_n, door_cnt, door_n;
  logic                    any_above, any_below, any_ahead;
  logic                    accept, here_call, home_req;

  assign call_ready = (state != EMERG);
  assign door       = (state == DOOR_OPEN) || (state == EMERG);
  assign moving     = (state == MOVE);

  assign accept    = call_valid && call_ready && (int'(call_floor) < NUM_FLOORS);
  assign here_call = accept && (call_floor == floor) &&
                     ((state == IDLE) || (state == DOOR_OPEN));
  assign set_mask  = (accept && !here_call) ? (NUM_FLOORS'(1) << call_floor) : '0;

  assign floor_step = (direction == DIR_UP) ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);
  // While travelling, decisions are taken relative to the floor about to be reached.
  assign scan_floor = (state == MOVE) ? floor_step : floor;

  elevator_req_scan #(.NUM_FLOORS(NUM_FLOORS)) u_scan (
    .pending   (pending),
    .floor     (scan_floor),
    .direction (direction),
    .any_above (any_above),
    .any_below (any_below),
    .any_ahead (any_ahead)
  );

`ifdef ELEVATOR_IDLE_HOME_EN
  logic [CNT_W-1:0] idle_cnt;
  logic             idle_qual;

  assign idle_qual = (state == IDLE) && (pending == '0) && (floor != '0) &&
                     !accept && !emergency;
  assign home_req  = idle_qual && (idle_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst)                          idle_cnt <= '0;
    else if (!idle_qual || home_req)  idle_cnt <= CNT_W'(IDLE_CYCLES - 1);
    else                              idle_cnt <= idle_cnt - CNT_W'(1);
  end
`else
  assign home_req = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    floor_n    = floor;
    dir_n      = direction;
    travel_n   = travel_cnt;
    door_n     = door_cnt;
    clear_mask = '0;

    case (state)
      IDLE: begin
        if (here_call) begin
          state_n = DOOR_OPEN;
          door_n  = DOOR_LOAD;
        end else if (pending[floor]) begin
          // call latched while leaving this floor, car is back here now
          state_n    = DOOR_OPEN;
          door_n     = DOOR_LOAD;
          clear_mask = NUM_FLOORS'(1) << floor;
        end else if (any_above || any_below) begin
          state_n  = MOVE;
          travel_n = TRAVEL_LOAD;
          if (!any_ahead) dir_n = ~direction;
        end
      end

      MOVE: begin
        if (travel_cnt != '0) begin
          travel_n = travel_cnt - CNT_W'(1);
        end else begin
          floor_n = floor_step;
          if (pending[floor_step]) begin
            state_n    = DOOR_OPEN;
            door_n     = DOOR_LOAD;
            clear_mask = NUM_FLOORS'(1) << floor_step;
          end else if (!any_above && !any_below) begin
            state_n = IDLE;
          end else begin
            travel_n = TRAVEL_LOAD;
            if (!any_ahead) dir_n = ~direction;
          end
          if (floor_step == '0)             dir_n = DIR_UP;
          else if (floor_step == TOP_FLOOR) dir_n = DIR_DOWN;
        end
      end

      DOOR_OPEN: begin
        if (here_call)              door_n  = DOOR_LOAD;
        else if (door_cnt != '0)    door_n  = door_cnt - CNT_W'(1);
        else                        state_n = IDLE;
      end

      EMERG: begin
        if (!emergency) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase

    if (emergency) begin
      state_n   = EMERG;
      floor_n   = floor;
      dir_n     = direction;
      travel_n  = '0;
      door_n    = '0;
      pending_n = '0;
    end else begin
      pending_n = (pending | set_mask | NUM_FLOORS'(home_req)) & ~clear_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      floor      <= '0;
      direction  <= DIR_UP;
      pending    <= '0;
      travel_cnt <= '0;
      door_cnt   <= '0;
    end else begin
      state      <= state_n;
      floor      <= floor_n;
      direction  <= dir_n;
      pending    <= pending_n;
      travel_cnt <= travel_n;
      door_cnt   <= door_n;
    end
  end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl; a 5-floor instance covers out-of-range calls.
module tb_elevator_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, emergency, call_valid;
  logic [1:0] call_floor;
  logic       call_ready, door, direction, moving;
  logic [1:0] floor;
  logic [3:0] pending;

  logic       call_valid5;
  logic [2:0] call_floor5;
  logic       call_ready5, door5, direction5, moving5;
  logic [2:0] floor5;
  logic [4:0] pending5;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  elevator_scan_ctrl u_dut (
    .clk(clk), .rst(rst), .emergency(emergency),
    .call_valid(call_valid), .call_floor(call_floor), .call_ready(call_ready),
    .floor(floor), .door(door), .direction(direction), .moving(moving), .pending(pending)
  );

  elevator_scan_ctrl #(.NUM_FLOORS(5)) u_dut5 (
    .clk(clk), .rst(rst), .emergency(emergency),
    .call_valid(call_valid5), .call_floor(call_floor5), .call_ready(call_ready5),
    .floor(floor5), .door(door5), .direction(direction5), .moving(moving5), .pending(pending5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic call(input logic [1:0] f);
    call_valid = 1'b1;
    call_floor = f;
    tick();
    call_valid = 1'b0;
  endtask

  // {floor, door, moving}
  function automatic logic [3:0] obs();
    return {floor, door, moving};
  endfunction

  // tbl holds one {floor,door,moving} nibble per cycle, first cycle in the leftmost digit
  task automatic run_seq(input string tag, input int n, input logic [63:0] tbl);
    for (int k = 0; k < n; k++) begin
      tick();
      check($sformatf("%s%0d", tag, k), obs(), tbl[4*(n-1-k) +: 4]);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    tick();
    check({tag, "_obs"}, obs(), 4'h0);
    check({tag, "_dir"}, direction, 1'b1);
    check({tag, "_pend"}, pending, 4'h0);
    check({tag, "_rdy"}, call_ready, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; emergency = 1'b0; call_valid = 1'b0; call_floor = '0;
    call_valid5 = 1'b0; call_floor5 = '0;
    @(negedge clk);
    do_reset("rst_a");

    // out-of-range call on the 5-floor instance, then its top floor
    call_valid5 = 1'b1; call_floor5 = 3'd5;
    tick();
    call_valid5 = 1'b0;
    check("oor_pend", pending5, 5'h00);
    check("oor_outs", {floor5, door5, moving5, direction5, call_ready5}, 7'b000_0011);
    call_valid5 = 1'b1; call_floor5 = 3'd4;
    tick();
    call_valid5 = 1'b0;
    check("top5_pend", pending5, 5'h10);

    // floor 0 -> 3, two cycles per floor, door three cycles
    call(2'd3);
    check("a_pend", pending, 4'h8);
    check("a_idle", obs(), 4'h0);
    run_seq("a", 10, 64'h115599EEEC);
    check("a_pend_clr", pending, 4'h0);
    check("a_dir_top", direction, 1'b0);

    // calls 3 then 1: stop at 1 on the way up
    do_reset("rst_b");
    call(2'd3);
    call(2'd1);
    check("b_k1", obs(), 4'h1);
    check("b_pend", pending, 4'hA);
    run_seq("b1_", 2, 64'h16);
    check("b_dir_at1", direction, 1'b1);
    check("b_pend_at1", pending, 4'h8);
    run_seq("b2_", 11, 64'h6645599EEEC);
    check("b_dir_top", direction, 1'b0);
    check("b_pend_end", pending, 4'h0);

    // from 3 heading down: serve 2, then 0, then late call to 3
    call(2'd2);
    check("c_pend2", pending, 4'h4);
    check("c_idle3", obs(), 4'hC);
    call(2'd0);
    check("c_k1", obs(), 4'hD);
    check("c_pend02", pending, 4'h5);
    run_seq("c1_", 2, 64'hDA);
    check("c_pend_at2", pending, 4'h1);
    call(2'd3);
    check("c_k4", obs(), 4'hA);
    check("c_pend03", pending, 4'h9);
    run_seq("c2_", 7, 64'hA899552);
    check("c_dir_at0", direction, 1'b1);
    check("c_pend_at0", pending, 4'h8);
    run_seq("c3_", 13, 64'h220115599EEEC);
    check("c_pend_end", pending, 4'h0);

    // emergency pulse between floors 1 and 2
    do_reset("rst_d");
    call(2'd2);
    ticks(3);
    check("d_travel", obs(), 4'h5);
    emergency = 1'b1;
    tick();
    check("d_em_obs", obs(), 4'h6);
    check("d_em_pend", pending, 4'h0);
    check("d_em_rdy", call_ready, 1'b0);
    call_valid = 1'b1; call_floor = 2'd3;
    tick();
    call_valid = 1'b0;
    check("d_em_hold", obs(), 4'h6);
    check("d_em_nocall", pending, 4'h0);
    emergency = 1'b0;
    tick();
    check("d_rel_obs", obs(), 4'h4);
    check("d_rel_rdy", call_ready, 1'b1);
    check("d_rel_pend", pending, 4'h0);
    tick();
    check("d_stay", obs(), 4'h4);

    // call to the current floor opens, and while open restarts the door timer
    call(2'd1);
    check("e_open", obs(), 4'h6);
    check("e_pend", pending, 4'h0);
    tick();
    check("e_k1", obs(), 4'h6);
    call(2'd1);
    check("e_restart", obs(), 4'h6);
    check("e_pend2", pending, 4'h0);
    run_seq("e", 3, 64'h664);

    // park at floor 2 and watch the idle boundary
    call(2'd2);
    check("f_pend", pending, 4'h4);
    ticks(6);
    check("f_parked", obs(), 4'h8);
    ticks(7);
    check("f_idle7", pending, 4'h0);
    tick();
`ifdef ELEVATOR_IDLE_HOME_EN
    check("f_home_set", pending, 4'h1);
    ticks(5);
    check("f_home_arr", obs(), 4'h2);
    check("f_home_pend", pending, 4'h0);
    check("f_home_dir", direction, 1'b1);
    ticks(3);
    check("f_home_idle", obs(), 4'h0);
`else
    check("f_no_home", pending, 4'h0);
    ticks(5);
    check("f_still", obs(), 4'h8);
    check("f_still_pend", pending, 4'h0);
`endif

    // reset in the middle of travel
    call(2'd3);
    ticks(2);
    check("g_moving", moving, 1'b1);
    do_reset("rst_g");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
